// File: rtl/hex_display_scheduler.sv
// Round-robin scheduler sharing six hex digits between NUM_SRC requesters.
// Optional leading-zero blanking is enabled by defining HEX_LZ_BLANK_EN.
module hex_display_scheduler #(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 50000000,
    parameter int SEL_W        = $clog2(NUM_SRC)
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [NUM_SRC*24-1:0]   src_value,
    output logic [NUM_SRC-1:0]      src_ack,
    input  logic                    hold,
    input  logic                    step_n,
    output logic [23:0]             digits,
    output logic [5:0]              blank,
    output logic [SEL_W-1:0]        sel,
    output logic                    active
);

    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DWELL   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] last;

    logic step_s1;
    logic step_s2;
    logic step_s3;
    logic step_pulse;

    logic                grant_found;
    logic [SEL_W-1:0]    grant_idx;
    logic [23:0]         grant_value;
    logic [NUM_SRC-1:0]  grant_onehot;
    logic [5:0]          blank_cap;

    logic load;
    logic unload;
    logic cnt_clr;
    logic cnt_inc;

    // Returns a mask of leading-zero digits above digit 0.
    function automatic logic [5:0] lz_blank(input logic [23:0] v);
        logic [5:0] b;
        logic       zero_above;
        b          = '0;
        zero_above = 1'b1;
        for (int d = 5; d >= 1; d--) begin
            zero_above = zero_above && (v[4*d +: 4] == 4'h0);
            b[d]       = zero_above;
        end
        return b;
    endfunction

    // Pushbutton is asynchronous: two flops to synchronize, a third for edge detect.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            step_s1 <= 1'b1;
            step_s2 <= 1'b1;
            step_s3 <= 1'b1;
        end else begin
            step_s1 <= step_n;
            step_s2 <= step_s1;
            step_s3 <= step_s2;
        end
    end

    assign step_pulse = step_s3 & ~step_s2;

    // Round-robin scan starting just after the last granted source.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_value = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last) + k) % NUM_SRC;
            if (!grant_found && src_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = SEL_W'(idx);
                grant_value = src_value[24*idx +: 24];
            end
        end
    end

    assign grant_onehot = NUM_SRC'(1) << grant_idx;

`ifdef HEX_LZ_BLANK_EN
    assign blank_cap = lz_blank(grant_value);
`else
    assign blank_cap = 6'b000000;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake: src_valid is a level; src_ack is a one-cycle pulse on the
    // edge that snapshots src_value. Requesters never wait on src_ack.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        unload     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (|src_valid) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (grant_found) begin
                    load       = 1'b1;
                    state_next = DWELL;
                end else begin
                    unload     = 1'b1;
                    state_next = IDLE;
                end
            end
            DWELL: begin
                if (step_pulse) begin
                    cnt_clr    = 1'b1;
                    state_next = CAPTURE;
                end else if (!hold) begin
                    if (cnt == CNT_LAST) begin
                        state_next = CAPTURE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            digits  <= '0;
            blank   <= 6'b111111;
            sel     <= '0;
            src_ack <= '0;
            active  <= 1'b0;
            last    <= SEL_W'(NUM_SRC - 1);
            cnt     <= '0;
        end else begin
            src_ack <= '0;
            if (load) begin
                digits  <= grant_value;
                sel     <= grant_idx;
                last    <= grant_idx;
                src_ack <= grant_onehot;
                active  <= 1'b1;
                blank   <= blank_cap;
                cnt     <= '0;
            end else if (unload) begin
                active <= 1'b0;
                blank  <= 6'b111111;
            end else if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler (NUM_SRC=4, DWELL_CYCLES=8).
module tb_hex_display_scheduler;

    localparam int NUM_SRC = 4;
    localparam int DWELL   = 8;
    localparam int SEL_W   = 2;

`ifdef HEX_LZ_BLANK_EN
    localparam logic [5:0] BLANK_ZERO = 6'b111110;
    localparam logic [5:0] BLANK_A30  = 6'b111000;
`else
    localparam logic [5:0] BLANK_ZERO = 6'b000000;
    localparam logic [5:0] BLANK_A30  = 6'b000000;
`endif

    logic                  CLOCK_50;
    logic                  reset;
    logic [NUM_SRC-1:0]    src_valid;
    logic [NUM_SRC*24-1:0] src_value;
    logic [NUM_SRC-1:0]    src_ack;
    logic                  hold;
    logic                  step_n;
    logic [23:0]           digits;
    logic [5:0]            blank;
    logic [SEL_W-1:0]      sel;
    logic                  active;

    int checks = 0;
    int errors = 0;

    hex_display_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .DWELL_CYCLES (DWELL),
        .SEL_W        (SEL_W)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .src_valid (src_valid),
        .src_value (src_value),
        .src_ack   (src_ack),
        .hold      (hold),
        .step_n    (step_n),
        .digits    (digits),
        .blank     (blank),
        .sel       (sel),
        .active    (active)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_digits"}, 32'(digits), 32'h0);
        check({tag, "_blank"},  32'(blank),  32'h3f);
        check({tag, "_sel"},    32'(sel),    32'h0);
        check({tag, "_ack"},    32'(src_ack), 32'h0);
        check({tag, "_active"}, 32'(active), 32'h0);
    endtask

    task automatic check_shown(input string tag, input logic [23:0] d, input int s, input logic [3:0] a);
        check({tag, "_digits"}, 32'(digits), 32'(d));
        check({tag, "_sel"},    32'(sel),    32'(s));
        check({tag, "_ack"},    32'(src_ack), 32'(a));
        check({tag, "_active"}, 32'(active), 32'h1);
    endtask

    initial begin
        reset     = 1'b1;
        src_valid = '0;
        src_value = '0;
        hold      = 1'b0;
        step_n    = 1'b1;
        tick(2);
        check_reset_values("rst");
        reset = 1'b0;

        // Two sources, round robin with wrap.
        src_value[0*24 +: 24] = 24'h123456;
        src_value[2*24 +: 24] = 24'habcdef;
        src_valid = 4'b0101;
        tick(1);
        check("cap_wait_ack", 32'(src_ack), 32'h0);
        check("cap_wait_active", 32'(active), 32'h0);
        tick(1);
        check_shown("first", 24'h123456, 0, 4'b0001);
        check("first_blank", 32'(blank), 32'h0);
        tick(1);
        check("ack_pulse_end", 32'(src_ack), 32'h0);
        tick(7);
        check_shown("dwell_end", 24'h123456, 0, 4'b0000);
        tick(1);
        check_shown("second", 24'habcdef, 2, 4'b0100);
        tick(9);
        check_shown("wrap", 24'h123456, 0, 4'b0001);

        // Single source refresh; mid-dwell value change held off.
        src_valid = 4'b1000;
        src_value[3*24 +: 24] = 24'h111111;
        tick(9);
        check_shown("solo", 24'h111111, 3, 4'b1000);
        tick(4);
        src_value[3*24 +: 24] = 24'h222222;
        tick(4);
        check_shown("solo_stale", 24'h111111, 3, 4'b0000);
        tick(1);
        check_shown("solo_refresh", 24'h222222, 3, 4'b1000);

        // Hold freezes the display for 50 cycles.
        hold = 1'b1;
        src_valid = 4'b1101;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check("hold_no_ack", 32'(src_ack), 32'h0);
        end
        check_shown("hold_end", 24'h222222, 3, 4'b0000);

        // Step pulse advances once, even while held.
        step_n = 1'b0;
        tick(3);
        check_shown("step_pending", 24'h222222, 3, 4'b0000);
        tick(1);
        check_shown("step_adv", 24'h123456, 0, 4'b0001);
        step_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("step_once_ack", 32'(src_ack), 32'h0);
            check("step_once_sel", 32'(sel), 32'h0);
        end

        // All valids drop: snapshot held to expiry, then idle.
        hold = 1'b0;
        src_valid = 4'b0000;
        tick(8);
        check_shown("drop_held", 24'h123456, 0, 4'b0000);
        check("drop_held_blank", 32'(blank), 32'h0);
        tick(1);
        check("idle_active", 32'(active), 32'h0);
        check("idle_blank", 32'(blank), 32'h3f);
        check("idle_ack", 32'(src_ack), 32'h0);

        // Step in idle has no effect.
        step_n = 1'b0;
        tick(4);
        step_n = 1'b1;
        tick(4);
        check("idle_step_active", 32'(active), 32'h0);
        check("idle_step_blank", 32'(blank), 32'h3f);

        // Reset with an ack pending, then arbitration restarts at source 0.
        src_valid = 4'b0100;
        tick(2);
        check_shown("pre_rst", 24'habcdef, 2, 4'b0100);
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        tick(1);
        reset = 1'b0;
        src_valid = 4'b0101;
        tick(2);
        check_shown("post_rst", 24'h123456, 0, 4'b0001);

        // Blanking of leading zeros.
        src_valid = 4'b0001;
        src_value[0*24 +: 24] = 24'h000000;
        tick(9);
        check_shown("zero", 24'h000000, 0, 4'b0001);
        check("zero_blank", 32'(blank), 32'(BLANK_ZERO));
        src_value[0*24 +: 24] = 24'h000a30;
        tick(9);
        check_shown("a30", 24'h000a30, 0, 4'b0001);
        check("a30_blank", 32'(blank), 32'(BLANK_A30));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
